// File: rtl/tristate_arb_pkg.sv
// Shared state encoding and default parameter values for tristate_bus_arbiter.
package tristate_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    localparam int DEFAULT_N           = 4;
    localparam int DEFAULT_TURN_CYCLES = 1;
    localparam int DEFAULT_MAX_HOLD    = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching from last+1 (mod N).
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 valid,
    output logic [$clog2(N)-1:0] index,
    output logic [N-1:0]         onehot
);

    localparam int IW = $clog2(N);

    int   cand_s;
    logic hit_s;

    // Walk the requesters in rotated order; the first hit latches index
    always_comb begin
        valid  = 1'b0;
        index  = {IW{1'b0}};
        cand_s = 0;
        hit_s  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand_s = (int'(last) + i >= N) ? (int'(last) + i - N) : (int'(last) + i);
            hit_s  = req[IW'(cand_s)] && !valid;
            index  = hit_s ? IW'(cand_s) : index;
            valid  = valid | req[IW'(cand_s)];
        end
        onehot        = {N{1'b0}};
        onehot[index] = valid;
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner arbiter for a shared tristate bus with idle turnaround between owners.
// Optional owner timeout is compiled in with `define TRISTATE_ARB_TIMEOUT_EN.
module tristate_bus_arbiter
    import tristate_arb_pkg::*;
#(
    parameter int N           = DEFAULT_N,
    parameter int TURN_CYCLES = DEFAULT_TURN_CYCLES,
    parameter int MAX_HOLD    = DEFAULT_MAX_HOLD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         en,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

    if (N < 2 || N > 16 || TURN_CYCLES < 1 || MAX_HOLD < 1) begin : g_bad_params
        $error("tristate_bus_arbiter: parameter out of range");
    end

    arb_state_t      state_r, state_nxt_s;
    logic [IW-1:0]   last_r, last_nxt_s;
    logic [TW-1:0]   turn_cnt_r, turn_cnt_nxt_s;
    logic [N-1:0]    gnt_r, gnt_nxt_s;
    logic [IW-1:0]   owner_r, owner_nxt_s;
    logic            busy_r, busy_nxt_s;
    logic            grant_s;
    logic            release_s;
    logic            pick_valid_s;
    logic [IW-1:0]   pick_index_s;
    logic [N-1:0]    pick_onehot_s;

    rr_pick #(.N(N)) u_rr_pick (
        .req    (req),
        .last   (last_r),
        .valid  (pick_valid_s),
        .index  (pick_index_s),
        .onehot (pick_onehot_s)
    );

`ifdef TRISTATE_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);

    logic [HW-1:0] hold_cnt_r, hold_cnt_nxt_s;

    assign release_s = !req[owner_r] || (hold_cnt_r == HOLD_LIMIT);

    // Owned-cycle count; a fresh grant is the first owned cycle
    always_comb begin
        if (grant_s) begin
            hold_cnt_nxt_s = HW'(1);
        end else if (state_nxt_s == OWN) begin
            hold_cnt_nxt_s = hold_cnt_r + HW'(1);
        end else begin
            hold_cnt_nxt_s = {HW{1'b0}};
        end
    end

    // Hold counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_r <= {HW{1'b0}};
        end else begin
            hold_cnt_r <= hold_cnt_nxt_s;
        end
    end
`else
    assign release_s = !req[owner_r];
`endif

    // Next state; grants are only issued from IDLE or at the end of turnaround
    always_comb begin
        state_nxt_s    = state_r;
        grant_s        = 1'b0;
        turn_cnt_nxt_s = {TW{1'b0}};
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s = OWN;
                    grant_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OWN: begin
                if (release_s) begin
                    state_nxt_s = TURN;
                end else begin
                    state_nxt_s = OWN;
                end
            end
            TURN: begin
                if (turn_cnt_r != TURN_LAST) begin
                    state_nxt_s    = TURN;
                    turn_cnt_nxt_s = turn_cnt_r + TW'(1);
                end else if (pick_valid_s) begin
                    state_nxt_s = OWN;
                    grant_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        last_nxt_s = grant_s ? pick_index_s : last_r;
        if (grant_s) begin
            gnt_nxt_s   = pick_onehot_s;
            owner_nxt_s = pick_index_s;
        end else if (state_nxt_s == OWN) begin
            gnt_nxt_s   = gnt_r;
            owner_nxt_s = owner_r;
        end else begin
            gnt_nxt_s   = {N{1'b0}};
            owner_nxt_s = {IW{1'b0}};
        end
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State and registered outputs; reset drops any partial turnaround
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            last_r     <= IW'(N - 1);
            turn_cnt_r <= {TW{1'b0}};
            gnt_r      <= {N{1'b0}};
            owner_r    <= {IW{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            last_r     <= last_nxt_s;
            turn_cnt_r <= turn_cnt_nxt_s;
            gnt_r      <= gnt_nxt_s;
            owner_r    <= owner_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign gnt   = gnt_r;
    assign en    = gnt_r;
    assign owner = owner_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench for tristate_bus_arbiter: instance u_dut (TURN_CYCLES=1) and u_dut3 (TURN_CYCLES=3),
// each driving four tristate drivers onto its own shared bus.
module tb_tristate_bus_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
    } exp_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       reset3 = 1'b1;
    logic [3:0] req    = 4'b0000;
    logic [3:0] req3   = 4'b0000;
    logic [3:0] gnt, en, gnt3, en3;
    logic [1:0] owner, owner3;
    logic       busy, busy3;
    wire  [3:0] bus, bus3;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    tristate_bus_arbiter #(.N(4), .TURN_CYCLES(1), .MAX_HOLD(8)) u_dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt), .en(en), .owner(owner), .busy(busy)
    );

    tristate_bus_arbiter #(.N(4), .TURN_CYCLES(3), .MAX_HOLD(8)) u_dut3 (
        .clk(clk), .reset(reset3), .req(req3), .gnt(gnt3), .en(en3), .owner(owner3), .busy(busy3)
    );

    // Driver i presents 9+i; contention or a wrong driver shows up as a wrong bus value
    for (genvar i = 0; i < 4; i++) begin : g_drv
        assign bus  = en[i]  ? 4'(9 + i) : 4'bzzzz;
        assign bus3 = en3[i] ? 4'(9 + i) : 4'bzzzz;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [3:0] g, input logic [3:0] n,
                           input logic [1:0] o, input logic b, input logic [3:0] bv);
        check({tag, ".gnt"},   32'(g), 32'(e.gnt));
        check({tag, ".en"},    32'(n), 32'(e.gnt));
        check({tag, ".owner"}, 32'(o), 32'(e.owner));
        check({tag, ".busy"},  32'(b), 32'(e.busy));
        if (e.gnt != 4'b0000) begin
            check({tag, ".bus"}, 32'(bv), 32'(4'd9 + 4'(e.owner)));
        end
    endtask

    // Monitor: each cycle the DUT presents its outputs, pop and compare
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            compare("main", e, gnt, en, owner, busy, bus);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            compare("turn3", e, gnt3, en3, owner3, busy3, bus3);
        end
        check("main.onehot0",  32'($onehot0(en)),  32'd1);
        check("turn3.onehot0", 32'($onehot0(en3)), 32'd1);
    end

    // Drive one cycle of inputs, then queue the outputs expected after the edge
    task automatic step(input int sel, input logic [3:0] r, input logic rs,
                        input logic [3:0] g, input logic [1:0] o, input logic b);
        exp_t e;
        e.gnt   = g;
        e.owner = o;
        e.busy  = b;
        if (sel == 0) begin
            req   = r;
            reset = rs;
        end else begin
            req3   = r;
            reset3 = rs;
        end
        @(posedge clk);
        if (sel == 0) begin
            q0.push_back(e);
        end else begin
            q1.push_back(e);
        end
        #1;
    endtask

    initial begin
        logic [3:0] cur;

        // reset, then requester 0 held for three cycles and released
        step(0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
        repeat (3) step(0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1);
        step(0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1);
        step(0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

        // 0110 after reset: 1 first, then 2 after one turn cycle
        step(0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
        repeat (2) step(0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1);
        step(0, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b1);
        step(0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
        step(0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1);
        step(0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

        // all four requesting, each dropping after 3 owned cycles; 0 re-requests at the end
        step(0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
        cur = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            repeat (3) step(0, cur, 1'b0, 4'(1 << k), 2'(k), 1'b1);
            cur[k] = 1'b0;
            if (k == 3) cur[0] = 1'b1;
            step(0, cur, 1'b0, 4'b0000, 2'd0, 1'b1);
        end
        step(0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1);
        step(0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1);
        step(0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

        // one-cycle pulse from IDLE is granted for exactly one cycle
        step(0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
        step(0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1);
        step(0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

        // owner releases while another requester arrives: honoured after the turn
        repeat (2) step(0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1);
        step(0, 4'b1000, 1'b0, 4'b0000, 2'd0, 1'b1);
        step(0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1);
        step(0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1);
        step(0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

        // reset in the second owned cycle of requester 2, then re-grant
        step(0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
        step(0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
        step(0, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0);
        step(0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
        step(0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1);
        step(0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

        // reset during turnaround
        step(0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1);
        step(0, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b1);
        step(0, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0);
        step(0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
        step(0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1);
        step(0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

        // 1001 held: timeout alternates owners, otherwise owner 0 keeps the bus
        step(0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
`ifdef TRISTATE_ARB_TIMEOUT_EN
        repeat (8) step(0, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1);
        step(0, 4'b1001, 1'b0, 4'b0000, 2'd0, 1'b1);
        repeat (8) step(0, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1);
        step(0, 4'b1001, 1'b0, 4'b0000, 2'd0, 1'b1);
        step(0, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1);
`else
        repeat (20) step(0, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1);
`endif
        step(0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1);
        step(0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

        // TURN_CYCLES=3: owner 0 releases with req[2] pending -> exactly 3 idle-enable cycles
        step(1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
        step(1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1);
        step(1, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1);
        repeat (3) step(1, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b1);
        step(1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
        repeat (3) step(1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1);
        step(1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

        @(negedge clk);
        #1;
        check("main.drained",  32'(q0.size()), 32'd0);
        check("turn3.drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Round-robin arbiter sharing one tristate bus among N requesters. Each requester owns one 4-bit `tristate` driver on the shared bus. This block produces the one-hot driver enables and the grants. It guarantees that at most one enable is high in any cycle, and it inserts idle turnaround cycles between owners so that two drivers never contend during handover.

## Interface
Parameters:
- N, 4: number of requesters/drivers; 2..16.
- TURN_CYCLES, 1: bus-idle cycles between owners; ≥1.
- MAX_HOLD, 8: maximum consecutive owned cycles when the timeout feature is compiled in; ≥1.

Ports:
- clk  in  1  the single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- req  in  N  request per requester; level, held while the bus is wanted.
- gnt  out  N  one-hot grant; the requester may present data while high.
- en  out  N  one-hot tristate enables, one per driver; identical to gnt.
- owner  out  $clog2(N)  index of the current owner; 0 when not OWN.
- busy  out  1  high in OWN and TURN.

## Operation
- States: IDLE, OWN, TURN.
- IDLE:
  - gnt=en=0, busy=0.
  - If any req is high at an edge, go to OWN with the winner's gnt/en set.
- Winner selection:
  - Round-robin search starting at last+1 (mod N), where last is the previous owner.
  - The first set req bit wins.
  - last is updated when a grant is issued.
- OWN:
  - gnt[o]=en[o]=1, owner=o, busy=1.
  - If req[o]=0 at an edge, go to TURN.
  - Other requesters' req never preempts the owner.
- TURN:
  - gnt=en=0, busy=1, owner=0.
  - Turn counter runs 0..TURN_CYCLES-1.
  - On the edge ending the last turn cycle: if any req is high, go to OWN with the new winner; otherwise go to IDLE.
- Invariants:
  - $onehot0(en) in every cycle.
  - en never moves directly between two bits; at least TURN_CYCLES all-zero cycles separate different owners.
- A released requester is re-granted only after the full turnaround, and only if no higher-priority requester (in round-robin order) is requesting.
- Reset:
  - Outputs: gnt=0, en=0, owner=0, busy=0.
  - Internal: state IDLE, last=N-1 (requester 0 has first priority), counters 0.

## Timing
- Grant latency from IDLE: req high before edge k → gnt/en high after edge k (1 cycle).
- Release latency: req[o] low before edge k → en[o] low after edge k. TURN occupies cycles k..k+TURN_CYCLES-1. The next owner's en rises after edge k+TURN_CYCLES.
- Owner releases while no one requests: TURN, then IDLE. The following grant takes 1 more cycle from IDLE.
- A req that pulses for one cycle while the block is in IDLE is granted for exactly 1 cycle.
- Simultaneous release by the owner and a new request from another requester: the new request is honoured after TURN, not immediately.
- Reset asserted mid-OWN or mid-TURN: en=0 after that edge; no partial turnaround is retained.

## Configuration
- TRISTATE_ARB_TIMEOUT_EN defined:
  - A hold counter (width $clog2(MAX_HOLD+1)) counts owned cycles.
  - After MAX_HOLD cycles in OWN the block goes to TURN even if req[o] is still high.
  - Normal round-robin then applies; the timed-out requester is lowest priority and is re-granted only if no other req is set.
- Not defined:
  - No hold counter.
  - The owner keeps the bus until it drops req.
  - MAX_HOLD is ignored.

## Structure
- Package tristate_arb_pkg:
  - state enum (IDLE, OWN, TURN).
  - Default constants for N, TURN_CYCLES, MAX_HOLD.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req, last.
  - Outputs: valid, index, onehot.
  - Instantiated once.
- Top level holds the FSM, the turn/hold counters and the output registers.
- The bench instantiates N `tristate` drivers on a shared wire to check that no value contention ever appears (no X on the bus while any en is high).

## Test plan
- Reset, then req=4'b0001 held: gnt=en=0001 one cycle after req; owner=0; busy=1; after release, en=0 for 1 cycle, then IDLE.
- req=4'b0110 from IDLE after reset: requester 1 granted first. On its release, 1 turn cycle with en=0000, then en=0100, owner=2.
- All four requesting, each dropping after 3 owned cycles: grant order 0,1,2,3,0. Every handover shows exactly TURN_CYCLES zero-enable cycles; $onehot0(en) always holds.
- TURN_CYCLES=3, owner 0 releases while req[2]=1: en=0000 for exactly 3 cycles, then en=0100.
- With TRISTATE_ARB_TIMEOUT_EN and MAX_HOLD=8, req=4'b1001 held constant: owner 0 for 8 cycles, turn, owner 3 for 8 cycles, turn, owner 0. Without the macro, owner 0 holds indefinitely.
- Reset asserted in the second owned cycle of requester 2: en=0, owner=0, busy=0 after that edge. With req still 4'b0100 after reset deasserts, requester 2 is re-granted after 1 cycle.
